// File: rtl/byte_seq_pkg.sv
// byte_seq_pkg: shared types and width helpers for the byte sequencer.
//   state_e  : burst FSM state (IDLE, RUN)
//   idx_w()  : beat-index width for a given bytes-per-word
//   len_w()  : burst-length width (must be able to hold BYTES itself)
package byte_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int idx_w(input int bytes);
    return $clog2(bytes);
  endfunction

  function automatic int len_w(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

endpackage

// File: rtl/byte_idx_counter.sv
// byte_idx_counter: beat index within one pass.
//   i_clk, i_rst_ : clock, synchronous active-low reset
//   i_load        : force index to zero (highest priority after reset)
//   i_en          : advance index by one
//   i_term        : terminal index (len-1)
//   o_idx         : current index
//   o_at_term     : current index equals the terminal value
//   o_wrap        : advancing from the terminal value this cycle (index returns to 0)
module byte_idx_counter #(
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_term,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_at_term,
  output logic             o_wrap
);

  logic [IDX_W-1:0] r_idx;

  assign o_idx     = r_idx;
  assign o_at_term = (r_idx == i_term);
  assign o_wrap    = i_en & o_at_term;

  always_ff @(posedge i_clk) begin
    if (!i_rst_)        r_idx <= '0;
    else if (i_load)    r_idx <= '0;
    else if (o_wrap)    r_idx <= '0;
    else if (i_en)      r_idx <= r_idx + IDX_W'(1);
  end

endmodule

// File: rtl/byte_sequencer.sv
// byte_sequencer: issues a burst of byte addresses base+0 .. base+len-1,
// one beat per accepted handshake, optionally repeating passes until abort.
//   i_clk, i_rst_      : clock, synchronous active-low reset
//   i_start, i_pc,
//   i_len, i_repeat    : burst request, captured in IDLE
//   i_abort            : terminate burst (wins over beat acceptance)
//   i_ready            : consumer accepts current beat
//   o_valid, o_res,
//   o_count, o_last    : current beat
//   o_busy             : burst in progress
//   o_done             : one-cycle pulse after a non-repeating burst ends
// Optional: define BYTE_SEQ_WRAP_EN to add i_wrap (captured with i_start),
// selecting aligned critical-byte-first wrap addressing within the word.
module byte_sequencer
  import byte_seq_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int BYTES  = 4,
  localparam int IDX_W  = idx_w(BYTES),
  localparam int LEN_W  = len_w(BYTES)
) (
  input  logic              i_clk,
  input  logic              i_rst_,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_repeat,
  input  logic              i_abort,
  input  logic              i_ready,
`ifdef BYTE_SEQ_WRAP_EN
  input  logic              i_wrap,
`endif
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_res,
  output logic [IDX_W-1:0]  o_count,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_term;
  logic              r_repeat;
  logic              r_done;
  logic              r_wrap;

  logic              w_run, w_go, w_accept, w_load;
  logic              w_at_term, w_wrap_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [LEN_W-1:0]  w_len_n;
  logic [ADDR_W-1:0] w_addr;

  assign w_run    = (r_state == RUN);
  assign w_go     = (r_state == IDLE) & i_start & ~i_abort;
  assign w_accept = w_run & i_ready;
  // Abort in RUN and a fresh start both rewind the index.
  assign w_load   = w_go | (w_run & i_abort);

  // Out-of-range lengths (0 or > BYTES) mean a full word.
  assign w_len_n = ((i_len == '0) || (i_len > LEN_W'(BYTES))) ? LEN_W'(BYTES) : i_len;

  byte_idx_counter #(.IDX_W(IDX_W)) u_idx (
    .i_clk     (i_clk),
    .i_rst_    (i_rst_),
    .i_load    (w_load),
    .i_en      (w_accept),
    .i_term    (r_term),
    .o_idx     (w_idx),
    .o_at_term (w_at_term),
    .o_wrap    (w_wrap_idx)
  );

`ifdef BYTE_SEQ_WRAP_EN
  // Wrap mode keeps the upper address bits and rolls the byte lane mod BYTES.
  assign w_addr = r_wrap ? {r_base[ADDR_W-1:IDX_W], r_base[IDX_W-1:0] + w_idx}
                         : r_base + ADDR_W'(w_idx);
`else
  assign w_addr = r_base + ADDR_W'(w_idx);
`endif

  // State register and captured burst parameters
  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_term   <= '0;
      r_repeat <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_run & ~i_abort & w_wrap_idx & ~r_repeat;
      if (w_go) begin
        r_base   <= i_pc;
        r_term   <= IDX_W'(w_len_n - LEN_W'(1));
        r_repeat <= i_repeat;
`ifdef BYTE_SEQ_WRAP_EN
        r_wrap   <= i_wrap;
`else
        r_wrap   <= 1'b0;
`endif
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_go) w_next = RUN;
      RUN: begin
        if (i_abort)                      w_next = IDLE;
        else if (w_wrap_idx && !r_repeat) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs; beat fields read as zero outside RUN
  always_comb begin
    o_busy  = w_run;
    o_valid = w_run;
    o_done  = r_done;
    o_last  = w_run & w_at_term;
    o_count = w_idx;
    o_res   = w_run ? w_addr : '0;
  end

endmodule

// File: tb/tb_byte_sequencer.sv
module tb_byte_sequencer;

  logic        clk, rst_, start, rep, abort, ready, wrap;
  logic [31:0] pc;
  logic [2:0]  len;
  logic        o_valid, o_last, o_busy, o_done;
  logic [31:0] o_res;
  logic [1:0]  o_count;

  int n_chk = 0, n_fail = 0, n_done = 0;
  bit armed = 0;

  // Reference model state: burst in flight, its parameters and beats taken in the pass
  bit          m_run = 0, m_rep = 0, m_wrap = 0, m_done = 0;
  logic [31:0] m_base = '0;
  int          m_len = 0, m_k = 0;

  logic [31:0] aq[$], eq[$];
  int          cq[$], ec[$];
  bit          lq[$], el[$];

  byte_sequencer #(.ADDR_W(32), .BYTES(4)) dut (
    .i_clk(clk), .i_rst_(rst_), .i_start(start), .i_pc(pc), .i_len(len),
    .i_repeat(rep), .i_abort(abort), .i_ready(ready),
`ifdef BYTE_SEQ_WRAP_EN
    .i_wrap(wrap),
`endif
    .o_valid(o_valid), .o_res(o_res), .o_count(o_count), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_addr();
    logic [31:0] a;
    logic [1:0]  lo;
    a  = m_base + 32'(m_k);
    lo = m_base[1:0] + 2'(m_k);
    if (m_wrap) a = {m_base[31:2], lo};
    return a;
  endfunction

  // Compare process: check DUT against the model, then advance the model
  // with the inputs that the next rising edge will sample.
  initial begin
    bit nd, el_exp;
    wait (armed);
    forever begin
      @(negedge clk);
      el_exp = m_run && (m_k == m_len - 1);
      chk("valid", 64'(o_valid), 64'(m_run));
      chk("busy",  64'(o_busy),  64'(m_run));
      chk("done",  64'(o_done),  64'(m_done));
      chk("last",  64'(o_last),  64'(el_exp));
      if (m_run) begin
        chk("res",   64'(o_res),   64'(model_addr()));
        chk("count", 64'(o_count), 64'(m_k));
      end
      if (o_valid && ready) begin
        aq.push_back(o_res); cq.push_back(int'(o_count)); lq.push_back(o_last);
      end
      if (o_done) n_done++;
      nd = 0;
      if (!rst_) begin
        m_run = 0; m_k = 0; m_base = '0; m_len = 0; m_rep = 0; m_wrap = 0;
      end else if (m_run) begin
        if (abort) begin
          m_run = 0; m_k = 0;
        end else if (ready) begin
          if (m_k == m_len - 1) begin
            m_k = 0;
            if (!m_rep) begin m_run = 0; nd = 1; end
          end else m_k++;
        end
      end else if (start && !abort) begin
        m_run = 1; m_k = 0; m_base = pc; m_rep = rep;
        m_len = (len == 0 || len > 4) ? 4 : int'(len);
`ifdef BYTE_SEQ_WRAP_EN
        m_wrap = wrap;
`else
        m_wrap = 0;
`endif
      end
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    aq.delete(); cq.delete(); lq.delete();
    eq.delete(); ec.delete(); el.delete();
    n_done = 0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [2:0] l, input bit r);
    start = 1; pc = a; len = l; rep = r;
    step();
    start = 0;
  endtask

  task automatic wait_idle(input int bound, input bit toggle);
    int i;
    for (i = 0; i < bound; i++) begin
      step();
      if (!o_busy) break;
      if (toggle) ready = ~ready;
    end
    chk("idle_timeout", 64'(i < bound), 64'(1));
    step();
  endtask

  // Compare captured beats with the hand-written expectations
  task automatic cmp_q(input string nm);
    chk({nm, "_nbeats"}, 64'(aq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < aq.size(); i++)
      chk({nm, "_addr"}, 64'(aq[i]), 64'(eq[i]));
    for (int i = 0; i < ec.size() && i < cq.size(); i++)
      chk({nm, "_cnt"}, 64'(cq[i]), 64'(ec[i]));
    for (int i = 0; i < el.size() && i < lq.size(); i++)
      chk({nm, "_last"}, 64'(lq[i]), 64'(el[i]));
  endtask

  initial begin
    rst_ = 0; start = 0; pc = '0; len = '0; rep = 0; abort = 0; ready = 0; wrap = 0;
    @(posedge clk); #1;
    armed = 1;
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_busy",  64'(o_busy),  64'(0));
    chk("rst_done",  64'(o_done),  64'(0));
    chk("rst_res",   64'(o_res),   64'(0));
    chk("rst_count", 64'(o_count), 64'(0));
    step();
    rst_ = 1;

    // Linear burst, consumer always ready
    clear(); ready = 1;
    launch(32'h1000, 3'd4, 0);
    wait_idle(20, 0);
    eq = '{32'h1000, 32'h1001, 32'h1002, 32'h1003};
    ec = '{0, 1, 2, 3};
    el = '{0, 0, 0, 1};
    cmp_q("lin");
    chk("lin_done", 64'(n_done), 64'(1));

    // Same burst with ready alternating 1,0,1,0
    clear(); ready = 1;
    launch(32'h1000, 3'd4, 0);
    wait_idle(30, 1);
    eq = '{32'h1000, 32'h1001, 32'h1002, 32'h1003};
    cmp_q("stall");
    chk("stall_done", 64'(n_done), 64'(1));

    // Address carry out of the top bit is dropped
    clear(); ready = 1;
    launch(32'hFFFF_FFFE, 3'd4, 0);
    wait_idle(20, 0);
    eq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    cmp_q("carry");

    // Repeating len=3, start ignored mid-burst, abort on an accepted beat
    clear(); ready = 1;
    launch(32'h500, 3'd3, 1);
    step(); step();
    start = 1; pc = 32'h9999; len = 3'd1;
    step();
    start = 0;
    step(); step(); step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", 64'(o_busy), 64'(0));
    step(); step();
    chk("abort_nodone", 64'(n_done), 64'(0));
    eq = '{32'h500, 32'h501, 32'h502, 32'h500, 32'h501, 32'h502, 32'h500};
    ec = '{0, 1, 2, 0, 1, 2, 0};
    cmp_q("rep");

    // Reset mid-burst at index 2, then a fresh burst starts at index 0
    clear(); ready = 1;
    launch(32'h4000, 3'd4, 0);
    step(); step();
    chk("pre_rst_cnt", 64'(o_count), 64'(2));
    rst_ = 0;
    step();
    chk("mid_rst_valid", 64'(o_valid), 64'(0));
    chk("mid_rst_res",   64'(o_res),   64'(0));
    chk("mid_rst_cnt",   64'(o_count), 64'(0));
    chk("mid_rst_last",  64'(o_last),  64'(0));
    rst_ = 1;
    launch(32'h3000, 3'd4, 0);
    chk("post_rst_cnt", 64'(o_count), 64'(0));
    chk("post_rst_res", 64'(o_res),   64'(32'h3000));
    wait_idle(20, 0);

    // Abort together with start in IDLE stays idle
    abort = 1; start = 1; pc = 32'h7;
    step();
    abort = 0; start = 0;
    chk("idle_abort", 64'(o_busy), 64'(0));
    step();

    // Single-beat passes: last always set
    clear(); ready = 1;
    launch(32'h77, 3'd1, 1);
    step(); step(); step();
    abort = 1;
    step();
    abort = 0;
    step();
    eq = '{32'h77, 32'h77, 32'h77, 32'h77};
    ec = '{0, 0, 0, 0};
    el = '{1, 1, 1, 1};
    cmp_q("len1");

    // Out-of-range lengths behave as a full word
    clear();
    launch(32'h10, 3'd0, 0);
    wait_idle(20, 0);
    eq = '{32'h10, 32'h11, 32'h12, 32'h13};
    cmp_q("len0");
    clear();
    launch(32'h20, 3'd7, 0);
    wait_idle(20, 0);
    eq = '{32'h20, 32'h21, 32'h22, 32'h23};
    el = '{0, 0, 0, 1};
    cmp_q("len7");

`ifdef BYTE_SEQ_WRAP_EN
    clear(); wrap = 1;
    launch(32'h2002, 3'd4, 0);
    wrap = 0;
    wait_idle(20, 0);
    eq = '{32'h2002, 32'h2003, 32'h2000, 32'h2001};
    cmp_q("wrap");
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
